btb_write_ctrl: RTL and testbench

BTB_WRITE_CTRL -- requirements
Module: btb_write_ctrl

---
 rtl/btb_write_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_btb_write_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/btb_write_ctrl.sv
// Purpose : BTB write controller. It merges two branch-lane update requests into one
//           registered BTB write port, and it walks the whole BTB to invalidate it after
//           reset or flush.
// Latency : 1 cycle from request to btb_wen when the queue is empty. Otherwise the
//           request waits behind the queued entries, one write per cycle.
// Backpres: none. Requests that do not fit in the DEPTH-entry queue are discarded
//           (newest first) and flagged on drop.
//
// Ports:
//   clk, rst_n                 single clock, synchronous active-low reset
//   req{0,1}_wen/_addr/_data   lane 0 (older) / lane 1 (younger) BTB update requests
//   flush                      restart the full-BTB invalidation walk
//   btb_wen/_addr/_data        registered BTB write port
//   busy                       invalidation walk in progress
//   drop                       one or more requests discarded this cycle
//   drop_count                 saturating count of discarded requests
//                              (only when BTB_WCTRL_STATS_EN is defined, else 0)
module btb_write_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_wen,
  input  logic [10:0] req0_addr,
  input  logic [15:0] req0_data,
  input  logic        req1_wen,
  input  logic [10:0] req1_addr,
  input  logic [15:0] req1_data,
  input  logic        flush,
  output logic        btb_wen,
  output logic [10:0] btb_addr,
  output logic [15:0] btb_data,
  output logic        busy,
  output logic        drop,
  output logic [15:0] drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state;
  logic [10:0]   clr_idx;
  logic [10:0]   q_addr [DEPTH];
  logic [15:0]   q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [OW-1:0] occ;

  logic          merge;
  logic          v0;
  logic          v1;
  logic          has_head;
  logic          run_ok;
  logic [10:0]   byp_addr;
  logic [15:0]   byp_data;
  logic          c0_vld;
  logic          c1_vld;
  logic [10:0]   c0_addr;
  logic [15:0]   c0_data;
  logic [10:0]   c1_addr;
  logic [15:0]   c1_data;
  logic [OW-1:0] space;
  logic          acc0;
  logic          acc1;
  logic [1:0]    n_drop;

  // When both lanes hit the same index, the younger lane's data wins.
  // The older request is absorbed quietly and is not counted as dropped.
  assign merge    = req0_wen & req1_wen & (req0_addr == req1_addr);
  assign v0       = req0_wen & ~merge;
  assign v1       = req1_wen;
  assign has_head = (occ != '0);
  assign run_ok   = (state == ST_RUN) & ~flush;

  // The oldest incoming request goes straight to the output only when the queue is empty.
  assign byp_addr = v0 ? req0_addr : req1_addr;
  assign byp_data = v0 ? req0_data : req1_data;

  // c0/c1 are the requests offered to the queue this cycle, in lane order.
  always_comb begin
    c0_vld  = 1'b0;
    c1_vld  = 1'b0;
    c0_addr = req1_addr;
    c0_data = req1_data;
    c1_addr = req1_addr;
    c1_data = req1_data;
    if (has_head) begin
      c0_vld = v0 | v1;
      c1_vld = v0 & v1;
      if (v0) begin
        c0_addr = req0_addr;
        c0_data = req0_data;
      end
    end else begin
      // Lane 0 took the bypass, so only lane 1 is left for the queue.
      c0_vld = v0 & v1;
    end
  end

  // The head leaves the queue on this same edge, so its slot is free for an incoming entry.
  assign space  = OW'(DEPTH) - occ + OW'(has_head);
  assign acc0   = c0_vld & (space != '0);
  assign acc1   = c1_vld & (space >= OW'(2));
  assign n_drop = 2'(c0_vld & ~acc0) + 2'(c1_vld & ~acc1);
  assign drop   = rst_n & run_ok & (n_drop != 2'd0);

  // Queue storage. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_n && run_ok) begin
      if (acc0) begin
        q_addr[tail] <= c0_addr;
        q_data[tail] <= c0_data;
      end
      if (acc1) begin
        q_addr[tail + PW'(1)] <= c1_addr;
        q_data[tail + PW'(1)] <= c1_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_idx  <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      btb_wen  <= 1'b0;
      btb_addr <= '0;
      btb_data <= '0;
      busy     <= 1'b1;
    end else if (flush) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      btb_wen <= 1'b0;
      busy    <= 1'b1;
    end else if (state == ST_CLEAR) begin
      btb_wen  <= 1'b1;
      btb_addr <= clr_idx;
      btb_data <= '0;
      busy     <= 1'b1;
      clr_idx  <= clr_idx + 11'd1;
      if (clr_idx == 11'h7FF) begin
        state <= ST_RUN;
      end
    end else begin
      busy <= 1'b0;
      if (has_head) begin
        btb_wen  <= 1'b1;
        btb_addr <= q_addr[head];
        btb_data <= q_data[head];
        head     <= head + PW'(1);
      end else if (v0 | v1) begin
        btb_wen  <= 1'b1;
        btb_addr <= byp_addr;
        btb_data <= byp_data;
      end else begin
        btb_wen <= 1'b0;
      end
      tail <= tail + PW'(acc0) + PW'(acc1);
      occ  <= occ - OW'(has_head) + OW'(acc0) + OW'(acc1);
    end
  end

`ifdef BTB_WCTRL_STATS_EN
  logic [15:0] cnt;
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, cnt} + 17'(n_drop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drop) begin
      cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign drop_count = cnt;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_btb_write_ctrl.sv
module tb_btb_write_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_wen, req1_wen, flush;
  logic [10:0] req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        btb_wen, busy, drop;
  logic [10:0] btb_addr;
  logic [15:0] btb_data;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  btb_write_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_wen(req0_wen), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_wen(req1_wen), .req1_addr(req1_addr), .req1_data(req1_data),
    .flush(flush),
    .btb_wen(btb_wen), .btb_addr(btb_addr), .btb_data(btb_data),
    .busy(busy), .drop(drop), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [10:0] a;
    logic [15:0] d;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the pending writes, in order, and the expected registered outputs.
  ent_t        mq[$];
  bit          m_clear = 1'b1;
  int          m_clr   = 0;
  bit          e_valid = 1'b0;
  logic        e_wen;
  logic [10:0] e_addr;
  logic [15:0] e_data;
  logic        e_busy;
  int          e_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f,
                     input logic w0, input logic [10:0] a0, input logic [15:0] d0,
                     input logic w1, input logic [10:0] a1, input logic [15:0] d1);
    ent_t inc[$];
    ent_t out;
    int   dropped;
    int   cnt_exp;
    rst_n = r; flush = f;
    req0_wen = w0; req0_addr = a0; req0_data = d0;
    req1_wen = w1; req1_addr = a1; req1_data = d1;
    @(negedge clk);
    if (e_valid) begin
      chk("btb_wen", 32'(btb_wen), 32'(e_wen));
      if (e_wen) begin
        chk("btb_addr", 32'(btb_addr), 32'(e_addr));
        chk("btb_data", 32'(btb_data), 32'(e_data));
      end
      chk("busy", 32'(busy), 32'(e_busy));
`ifdef BTB_WCTRL_STATS_EN
      cnt_exp = e_cnt;
`else
      cnt_exp = 0;
`endif
      chk("drop_count", 32'(drop_count), 32'(cnt_exp));
    end
    dropped = 0;
    if (!r) begin
      m_clear = 1'b1; m_clr = 0; mq.delete();
      e_wen = 1'b0; e_addr = '0; e_data = '0; e_busy = 1'b1; e_cnt = 0; e_valid = 1'b1;
    end else if (f) begin
      m_clear = 1'b1; m_clr = 0; mq.delete();
      e_wen = 1'b0; e_busy = 1'b1;
    end else if (m_clear) begin
      e_wen = 1'b1; e_addr = 11'(m_clr); e_data = '0; e_busy = 1'b1;
      m_clr++;
      if (m_clr == 2048) m_clear = 1'b0;
    end else begin
      e_busy = 1'b0;
      if (w0 && !(w1 && a0 == a1)) inc.push_back(ent_t'{a: a0, d: d0});
      if (w1) inc.push_back(ent_t'{a: a1, d: d1});
      e_wen = 1'b0;
      if (mq.size() > 0) begin
        out = mq.pop_front(); e_wen = 1'b1;
      end else if (inc.size() > 0) begin
        out = inc.pop_front(); e_wen = 1'b1;
      end
      if (e_wen) begin
        e_addr = out.a; e_data = out.d;
      end
      foreach (inc[i]) mq.push_back(inc[i]);
      while (mq.size() > DEPTH) begin
        void'(mq.pop_back());
        dropped++;
      end
      e_cnt = (e_cnt + dropped > 65535) ? 65535 : e_cnt + dropped;
    end
    chk("drop", 32'(drop), 32'(dropped > 0));
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input logic r, input logic f, input int pidle);
    logic        w0 = ($urandom_range(0, 99) >= pidle);
    logic        w1 = ($urandom_range(0, 99) >= pidle);
    logic [10:0] a0 = 11'($urandom_range(0, 7));
    logic [10:0] a1 = 11'($urandom_range(0, 7));
    logic [15:0] d0 = 16'($urandom);
    logic [15:0] d1 = 16'($urandom);
    cyc(r, f, w0, a0, d0, w1, a1, d1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    req0_wen = 1'b0; req0_addr = '0; req0_data = '0;
    req1_wen = 1'b0; req1_addr = '0; req1_data = '0;
    #1;
    // Reset with traffic present, then the full walk; requests during the walk are discarded.
    for (int i = 0; i < 3; i++) rnd(1'b0, 1'b0, 30);
    for (int i = 0; i < 2049; i++) rnd(1'b1, 1'b0, 30);
    idle(8);

    // Single lane-0 request into an empty queue (bypass path).
    cyc(1'b1, 1'b0, 1'b1, 11'h010, 16'h8123, 1'b0, '0, '0);
    idle(3);

    // Both lanes hit the same index: only lane 1 is written, no drop.
    cyc(1'b1, 1'b0, 1'b1, 11'h055, 16'h8001, 1'b1, 11'h055, 16'h8002);
    idle(3);

    // Sustained dual-lane traffic fills the queue and then overflows.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b0, 1'b1, 11'(16'h100 + 2 * i), 16'(16'h9000 + i),
          1'b1, 11'(16'h101 + 2 * i), 16'(16'hA000 + i));
    idle(10);

    // Random traffic with index collisions.
    for (int i = 0; i < 400; i++) rnd(1'b1, 1'b0, 35);
    idle(8);

    // Queue three entries, then flush: they must never reach the BTB.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b1, 11'(16'h200 + 2 * i), 16'(16'hB000 + i),
          1'b1, 11'(16'h201 + 2 * i), 16'(16'hC000 + i));
    rnd(1'b1, 1'b1, 0);
    for (int i = 0; i < 300; i++) rnd(1'b1, 1'b0, 30);
    rnd(1'b1, 1'b1, 30);                       // flush again mid-walk
    for (int i = 0; i < 2052; i++) rnd(1'b1, 1'b0, 30);
    for (int i = 0; i < 200; i++) rnd(1'b1, 1'b0, 10);

    // One-cycle reset at walk index 1000.
    rnd(1'b1, 1'b1, 30);
    for (int i = 0; i < 1000; i++) rnd(1'b1, 1'b0, 30);
    rnd(1'b0, 1'b0, 30);
    for (int i = 0; i < 2052; i++) rnd(1'b1, 1'b0, 30);
    for (int i = 0; i < 300; i++) rnd(1'b1, 1'b0, 20);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
